// File: rtl/wfq_pkg.sv
// wfq_pkg: shared definitions for the WFQ finish-time tag path.
//   N_DEF      default finish-time tag width
//   FLOW_W_DEF default flow id width (tag width minus 3)
//   state_t    tag scheduler FSM encodings
package wfq_pkg;

  localparam int N_DEF      = 16;
  localparam int FLOW_W_DEF = N_DEF - 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/wfq_free_slot_enc.sv
// wfq_free_slot_enc: combinational lowest-index free-slot priority encoder.
// Ports:
//   valid     in   DEPTH   occupancy vector of the tag store
//   slot      out  SLOT_W  lowest index whose valid bit is 0
//   none_free out  1       every slot is occupied (slot is 0 then)
module wfq_free_slot_enc #(
  parameter int DEPTH  = 16,
  parameter int SLOT_W = 4
) (
  input  logic [DEPTH-1:0]  valid,
  output logic [SLOT_W-1:0] slot,
  output logic              none_free
);

  // Walk from the top down so the last hit written is the lowest free index.
  always_comb begin
    slot      = '0;
    none_free = 1'b1;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        slot      = SLOT_W'(i);
        none_free = 1'b0;
      end
    end
  end

endmodule

// File: rtl/wfq_tag_sched.sv
// wfq_tag_sched: finish-time tag store with smallest-tag dequeue.
// Tags arriving from the finish-time stage are written into the lowest free
// slot of a register-based store. A dequeue request starts a linear scan over
// a frozen snapshot of the occupied slots (one slot per cycle), then returns
// the smallest tag (lowest slot wins ties) and frees its slot.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   ins_valid         tag insert strobe
//   ins_ftime         finish-time tag to insert (N bits)
//   ins_flow_id       owning flow (N-3 bits)
//   ins_drop          pulse: insert rejected, store was full
//   deq_req           dequeue request (ignored while busy)
//   deq_valid         pulse: deq_ftime / deq_flow_id carry the selected tag
//   deq_nack          pulse: dequeue refused, store was empty
//   deq_ftime         selected tag, holds when deq_valid is low
//   deq_flow_id       flow of the selected tag, holds when deq_valid is low
//   busy              scan or output cycle in progress
//   count             occupied slots (SLOT_W+1 bits)
//   full, empty       count == DEPTH, count == 0
module wfq_tag_sched
  import wfq_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int DEPTH  = 16,
  parameter int SLOT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ins_valid,
  input  logic [N-1:0]      ins_ftime,
  input  logic [N-4:0]      ins_flow_id,
  output logic              ins_drop,
  input  logic              deq_req,
  output logic              deq_valid,
  output logic              deq_nack,
  output logic [N-1:0]      deq_ftime,
  output logic [N-4:0]      deq_flow_id,
  output logic              busy,
  output logic [SLOT_W:0]   count,
  output logic              full,
  output logic              empty
);

  state_t            state;
  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  valid_d;
  logic [DEPTH-1:0]  scan_mask;
  logic [SLOT_W-1:0] idx;
  logic [SLOT_W-1:0] best_idx;
  logic [N-1:0]      best_ftime;
  logic [N-4:0]      best_flow;
  logic              best_hit;

  logic [N-1:0]      ftime_mem [DEPTH];
  logic [N-4:0]      flow_mem  [DEPTH];

  logic [SLOT_W-1:0] free_slot;
  logic              none_free;
  logic              ins_ok;
  logic              clr;
  logic              take;

  wfq_free_slot_enc #(
    .DEPTH  (DEPTH),
    .SLOT_W (SLOT_W)
  ) u_free_enc (
    .valid     (valid_q),
    .slot      (free_slot),
    .none_free (none_free)
  );

  // Free-slot search and full check both see the pre-clear valid vector, so a
  // full store drops an insert even in the cycle a slot is being released.
  assign ins_ok = ins_valid && !none_free;
  assign clr    = (state == ST_OUT);
  assign take   = scan_mask[idx] && (!best_hit || (ftime_mem[idx] < best_ftime));

  // The inserted slot is free and the cleared slot is occupied, so they never
  // collide.
  always_comb begin
    valid_d = valid_q;
    if (ins_ok) valid_d[free_slot] = 1'b1;
    if (clr)    valid_d[best_idx]  = 1'b0;
  end

  assign busy  = (state != ST_IDLE);
  assign full  = (count == (SLOT_W+1)'(DEPTH));
  assign empty = (count == '0);

  // ---- tag store (data only, contents undefined after reset) ----
  always_ff @(posedge clk) begin
    if (ins_ok) begin
      ftime_mem[free_slot] <= ins_ftime;
      flow_mem[free_slot]  <= ins_flow_id;
    end
  end

  // ---- occupancy, scan FSM and registered outputs ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      valid_q     <= '0;
      count       <= '0;
      scan_mask   <= '0;
      idx         <= '0;
      best_idx    <= '0;
      best_ftime  <= '0;
      best_flow   <= '0;
      best_hit    <= 1'b0;
      ins_drop    <= 1'b0;
      deq_valid   <= 1'b0;
      deq_nack    <= 1'b0;
      deq_ftime   <= '0;
      deq_flow_id <= '0;
    end else begin
      valid_q   <= valid_d;
      ins_drop  <= ins_valid && none_free;
      deq_valid <= 1'b0;
      deq_nack  <= 1'b0;

      case ({ins_ok, clr})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      case (state)
        ST_IDLE: begin
          if (deq_req) begin
            if (count != '0) begin
              scan_mask  <= valid_q;
              idx        <= '0;
              best_ftime <= '1;
              best_hit   <= 1'b0;
              state      <= ST_SCAN;
            end else begin
              deq_nack <= 1'b1;
            end
          end
        end
        ST_SCAN: begin
          if (take) begin
            best_idx   <= idx;
            best_ftime <= ftime_mem[idx];
            best_flow  <= flow_mem[idx];
            best_hit   <= 1'b1;
          end
          if (idx == SLOT_W'(DEPTH - 1)) begin
            state <= ST_OUT;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_OUT: begin
          deq_valid   <= 1'b1;
          deq_ftime   <= best_ftime;
          deq_flow_id <= best_flow;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wfq_tag_sched.sv
module tb_wfq_tag_sched;

  localparam int N      = 16;
  localparam int DEPTH  = 16;
  localparam int SLOT_W = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            ins_valid;
  logic [N-1:0]    ins_ftime;
  logic [N-4:0]    ins_flow_id;
  logic            ins_drop;
  logic            deq_req;
  logic            deq_valid;
  logic            deq_nack;
  logic [N-1:0]    deq_ftime;
  logic [N-4:0]    deq_flow_id;
  logic            busy;
  logic [SLOT_W:0] count;
  logic            full;
  logic            empty;

  int total = 0;
  int bad   = 0;

  wfq_tag_sched #(.N(N), .DEPTH(DEPTH), .SLOT_W(SLOT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .ins_valid   (ins_valid),
    .ins_ftime   (ins_ftime),
    .ins_flow_id (ins_flow_id),
    .ins_drop    (ins_drop),
    .deq_req     (deq_req),
    .deq_valid   (deq_valid),
    .deq_nack    (deq_nack),
    .deq_ftime   (deq_ftime),
    .deq_flow_id (deq_flow_id),
    .busy        (busy),
    .count       (count),
    .full        (full),
    .empty       (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ins(input int flow, input int ft);
    ins_valid   = 1'b1;
    ins_flow_id = (N-3)'(flow);
    ins_ftime   = N'(ft);
    tick();
    ins_valid   = 1'b0;
  endtask

  // Issue a dequeue and wait for deq_valid; optionally insert a tag during the
  // wait (ins_at = number of cycles after the request edge, 16 = OUT cycle).
  task automatic do_deq(input string tag, input int exp_ft, input int exp_flow,
                        input int ins_at, input int i_flow, input int i_ft);
    int  n;
    bit  got;
    deq_req = 1'b1;
    tick();
    deq_req = 1'b0;
    chk({tag, "_busy"}, int'(busy), 1);
    n   = 0;
    got = 0;
    while (!got && n < 40) begin
      ins_valid   = (n == ins_at);
      ins_flow_id = (N-3)'(i_flow);
      ins_ftime   = N'(i_ft);
      tick();
      n++;
      if (deq_valid) got = 1;
    end
    ins_valid = 1'b0;
    chk({tag, "_seen"}, int'(got), 1);
    chk({tag, "_lat"},  n, 17);
    chk({tag, "_ft"},   int'(deq_ftime), exp_ft);
    chk({tag, "_flow"}, int'(deq_flow_id), exp_flow);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int seen;
    rst         = 1'b1;
    ins_valid   = 1'b0;
    ins_ftime   = '0;
    ins_flow_id = '0;
    deq_req     = 1'b0;
    tick();
    tick();
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full",  int'(full), 0);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_dv",    int'(deq_valid), 0);
    chk("rst_nack",  int'(deq_nack), 0);
    chk("rst_drop",  int'(ins_drop), 0);
    chk("rst_dft",   int'(deq_ftime), 0);
    rst = 1'b0;
    tick();

    // Dequeue on an empty store is refused.
    deq_req = 1'b1;
    tick();
    deq_req = 1'b0;
    chk("nack_pulse", int'(deq_nack), 1);
    chk("nack_dv",    int'(deq_valid), 0);
    chk("nack_busy",  int'(busy), 0);
    chk("nack_empty", int'(empty), 1);
    tick();
    chk("nack_clear", int'(deq_nack), 0);

    // Smallest tag first.
    ins(3, 40);
    ins(7, 25);
    ins(1, 60);
    chk("three_count", int'(count), 3);
    do_deq("deq25", 25, 7, -1, 0, 0);
    chk("deq25_count", int'(count), 2);
    tick();
    chk("deq25_hold", int'(deq_ftime), 25);
    chk("deq25_dvlo", int'(deq_valid), 0);
    do_deq("deq40", 40, 3, -1, 0, 0);
    do_deq("deq60", 60, 1, -1, 0, 0);
    chk("drain_empty", int'(empty), 1);

    // Equal tags resolve to the lower slot.
    ins(2, 50);
    ins(9, 50);
    do_deq("tie_a", 50, 2, -1, 0, 0);
    do_deq("tie_b", 50, 9, -1, 0, 0);
    chk("tie_count", int'(count), 0);

    // Full store: overflow insert dropped, including during the OUT cycle.
    for (int i = 0; i < DEPTH; i++) ins(i, 100 + i);
    chk("fill_full",  int'(full), 1);
    chk("fill_count", int'(count), 16);
    ins(20, 5);
    chk("ovf_drop",  int'(ins_drop), 1);
    chk("ovf_count", int'(count), 16);
    tick();
    chk("ovf_droplo", int'(ins_drop), 0);
    do_deq("fullout", 100, 0, 16, 21, 3);
    chk("fullout_drop",  int'(ins_drop), 1);
    chk("fullout_count", int'(count), 15);
    chk("fullout_full",  int'(full), 0);
    do_deq("after_full", 101, 1, -1, 0, 0);
    pulse_rst();
    chk("clean_count", int'(count), 0);

    // Insert during scan is not a candidate; non-full insert in OUT keeps count.
    ins(4, 10);
    ins(6, 30);
    do_deq("midscan", 10, 4, 3, 5, 1);
    chk("midscan_count", int'(count), 2);
    do_deq("late1", 1, 5, 16, 8, 70);
    chk("late1_count", int'(count), 2);
    do_deq("d30", 30, 6, -1, 0, 0);
    do_deq("d70", 70, 8, -1, 0, 0);
    chk("final_empty", int'(empty), 1);

    // Asynchronous reset in the middle of a scan aborts the dequeue.
    ins(1, 5);
    deq_req = 1'b1;
    tick();
    deq_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("pre_rst_busy", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy",  int'(busy), 0);
    chk("arst_count", int'(count), 0);
    chk("arst_empty", int'(empty), 1);
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (deq_valid) seen = 1;
    end
    chk("arst_no_dv",  seen, 0);
    chk("arst_count2", int'(count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
